// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Imported by the interface, the load-use comparator and the top.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_e;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam int unsigned FLUSH_CNT_W = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the pipeline registers and the control outputs
// that drive them; master is the pipeline side, slave the controller.
interface pipeline_hazard_ctrl_if;
    import pipeline_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic                  mem_branch_taken;
    logic                  dmem_busy;
    logic                  pc_write;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  id_ex_hold;
    logic                  ex_mem_flush;
    logic                  ex_mem_hold;
    logic [1:0]            ctrl_state;

    modport master (
        output id_rs, id_rt, id_uses_rt,
        output ex_mem_read, ex_rt,
        output mem_branch_taken, dmem_busy,
        input  pc_write, if_id_write, if_id_flush,
        input  id_ex_flush, id_ex_hold,
        input  ex_mem_flush, ex_mem_hold,
        input  ctrl_state
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt,
        input  ex_mem_read, ex_rt,
        input  mem_branch_taken, dmem_busy,
        output pc_write, if_id_write, if_id_flush,
        output id_ex_flush, id_ex_hold,
        output ex_mem_flush, ex_mem_hold,
        output ctrl_state
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// Load-use comparator: a load in ID/EX whose destination is read
// by the instruction in IF/ID. $zero never creates a dependency.
module hazard_load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    output logic                  load_use
);

    logic rs_hit;
    logic rt_hit;

    // Match against rs always, against rt only when it is a source
    always_comb begin
        rs_hit   = (ex_rt == id_rs);
        rt_hit   = id_uses_rt && (ex_rt == id_rt);
        load_use = ex_mem_read && (ex_rt != REG_ZERO)
                   && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze controller for the 5-stage pipeline.
// Optional HAZARD_STATS_EN adds saturating stall/flush counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned STAT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef HAZARD_STATS_EN
    output logic [STAT_W-1:0]    stall_cycles,
    output logic [STAT_W-1:0]    flush_cycles,
`endif
    pipeline_hazard_ctrl_if.slave hz
);

    localparam logic [FLUSH_CNT_W-1:0] CNT_INIT =
        FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    ctrl_state_e            state_q, state_d;
    logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
    logic                   load_use;
    logic                   in_flush;
    logic                   busy;
    logic                   br;

    hazard_load_use_detect u_lu (
        .id_rs       (hz.id_rs),
        .id_rt       (hz.id_rt),
        .id_uses_rt  (hz.id_uses_rt),
        .ex_mem_read (hz.ex_mem_read),
        .ex_rt       (hz.ex_rt),
        .load_use    (load_use)
    );

    // State and flush counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and controls; cases are made exclusive so the
    // priority busy > branch > load-use is explicit in the terms
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        hz.pc_write     = 1'b0;
        hz.if_id_write  = 1'b0;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_flush  = 1'b0;
        hz.id_ex_hold   = 1'b0;
        hz.ex_mem_flush = 1'b0;
        hz.ex_mem_hold  = 1'b0;
        in_flush        = (state_q == FLUSH);
        busy            = hz.dmem_busy;
        br              = hz.mem_branch_taken;
        unique case (1'b1)
            busy: begin
                hz.id_ex_hold  = 1'b1;
                hz.ex_mem_hold = 1'b1;
                state_d = in_flush ? FLUSH : MEM_WAIT;
            end
            !busy && in_flush: begin
                hz.pc_write    = 1'b1;
                hz.if_id_write = 1'b1;
                hz.if_id_flush = 1'b1;
                hz.id_ex_flush = 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            !busy && !in_flush && br: begin
                hz.pc_write     = 1'b1;
                hz.if_id_write  = 1'b1;
                hz.if_id_flush  = 1'b1;
                hz.id_ex_flush  = 1'b1;
                hz.ex_mem_flush = 1'b1;
                state_d = RUN;
                cnt_d   = '0;
                if (FLUSH_CYCLES > 1) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_INIT;
                end
            end
            !busy && !in_flush && !br && load_use: begin
                hz.id_ex_flush = 1'b1;
                state_d = RUN;
            end
            !busy && !in_flush && !br && !load_use: begin
                hz.pc_write    = 1'b1;
                hz.if_id_write = 1'b1;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
        if (!reset) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.if_id_flush  = 1'b0;
            hz.id_ex_flush  = 1'b0;
            hz.id_ex_hold   = 1'b0;
            hz.ex_mem_flush = 1'b0;
            hz.ex_mem_hold  = 1'b0;
        end
    end

    // Debug view of the current state
    always_comb begin
        hz.ctrl_state = state_q;
    end

`ifdef HAZARD_STATS_EN
    // Saturating counters of stalled and flushed cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (!hz.pc_write && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (hz.if_id_flush && (flush_cycles != '1))
                flush_cycles <= flush_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with FLUSH_CYCLES=3.
// Also checks the stats counters when HAZARD_STATS_EN is defined.
module tb_pipeline_hazard_ctrl;

    localparam logic [6:0] C_ZERO = 7'b0000000;
    localparam logic [6:0] C_NORM = 7'b1100000;
    localparam logic [6:0] C_LU   = 7'b0001000;
    localparam logic [6:0] C_BR   = 7'b1111010;
    localparam logic [6:0] C_FL   = 7'b1111000;
    localparam logic [6:0] C_HOLD = 7'b0000101;

    logic clk;
    logic reset;
    int   vectors;
    int   errors;
    logic [6:0] ctl;

    pipeline_hazard_ctrl_if hz ();

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_cycles;
`endif

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES (3),
        .STAT_W       (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef HAZARD_STATS_EN
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles),
`endif
        .hz           (hz.slave)
    );

    assign ctl = {hz.pc_write, hz.if_id_write, hz.if_id_flush,
                  hz.id_ex_flush, hz.id_ex_hold,
                  hz.ex_mem_flush, hz.ex_mem_hold};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cs(input string tag, input logic [6:0] ec,
                      input logic [1:0] es);
        #2;
        chk({tag, ".ctl"}, {25'd0, ctl}, {25'd0, ec});
        chk({tag, ".st"}, {30'd0, hz.ctrl_state}, {30'd0, es});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.id_rs            = 5'd0;
        hz.id_rt            = 5'd0;
        hz.id_uses_rt       = 1'b0;
        hz.ex_mem_read      = 1'b0;
        hz.ex_rt            = 5'd0;
        hz.mem_branch_taken = 1'b0;
        hz.dmem_busy        = 1'b0;
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        reset   = 1'b0;
        idle();
        #10;
        cs("reset", C_ZERO, 2'd0);
`ifdef HAZARD_STATS_EN
        chk("rst_stall", stall_cycles, 32'd0);
        chk("rst_flush", flush_cycles, 32'd0);
`endif
        reset = 1'b1;
        tick();
        cs("idle", C_NORM, 2'd0);

        hz.ex_mem_read = 1'b1;
        hz.ex_rt       = 5'd8;
        hz.id_rs       = 5'd8;
        cs("lu", C_LU, 2'd0);
        tick();
        hz.ex_mem_read = 1'b0;
        cs("lu_after", C_NORM, 2'd0);
`ifdef HAZARD_STATS_EN
        chk("lu_stall", stall_cycles, 32'd1);
        chk("lu_flush", flush_cycles, 32'd0);
`endif

        idle();
        hz.ex_mem_read = 1'b1;
        cs("zero_reg", C_NORM, 2'd0);
        hz.ex_rt = 5'd9;
        hz.id_rt = 5'd9;
        hz.id_rs = 5'd1;
        cs("rt_unused", C_NORM, 2'd0);
        hz.id_uses_rt = 1'b1;
        cs("rt_used", C_LU, 2'd0);
        idle();
        tick();

        hz.mem_branch_taken = 1'b1;
        cs("br0", C_BR, 2'd0);
        tick();
        hz.mem_branch_taken = 1'b0;
        cs("br1", C_FL, 2'd1);
        tick();
        cs("br2", C_FL, 2'd1);
        tick();
        cs("br_done", C_NORM, 2'd0);

        hz.mem_branch_taken = 1'b1;
        cs("fb0", C_BR, 2'd0);
        tick();
        hz.mem_branch_taken = 1'b0;
        hz.dmem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cs("fb_hold", C_HOLD, 2'd1);
            tick();
        end
        hz.dmem_busy = 1'b0;
        cs("fb_f1", C_FL, 2'd1);
        tick();
        cs("fb_f2", C_FL, 2'd1);
        tick();
        cs("fb_done", C_NORM, 2'd0);

        hz.dmem_busy        = 1'b1;
        hz.mem_branch_taken = 1'b1;
        hz.ex_mem_read      = 1'b1;
        hz.ex_rt            = 5'd8;
        hz.id_rs            = 5'd8;
        cs("all0", C_HOLD, 2'd0);
        tick();
        cs("all1", C_HOLD, 2'd2);
        tick();
        hz.dmem_busy = 1'b0;
        cs("all_br", C_BR, 2'd2);
        tick();
        idle();
        cs("all_f1", C_FL, 2'd1);
        tick();
        cs("all_f2", C_FL, 2'd1);
        tick();
        cs("all_done", C_NORM, 2'd0);

        hz.mem_branch_taken = 1'b1;
        tick();
        hz.mem_branch_taken = 1'b0;
        cs("rf_fl", C_FL, 2'd1);
        reset = 1'b0;
        cs("rf_rst", C_ZERO, 2'd0);
`ifdef HAZARD_STATS_EN
        chk("rf_stall", stall_cycles, 32'd0);
        chk("rf_flush", flush_cycles, 32'd0);
`endif
        #1;
        reset = 1'b1;
        tick();
        cs("rf_run", C_NORM, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
